// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl: bit-serial controller for an external 1-bit ALU slice.
// Operands are latched on an accepted start and walked through the slice
// LSB first, one bit per clock. SLT adds one fix-up cycle that folds the
// sign and overflow into bit 0.
// Optional feature: define ALU_SERIAL_ZERO_FLAG_EN to register a zero flag
// (final result == 0) that updates together with done; otherwise zero is 0.
// Handshake: start is sampled only in IDLE; busy is high while the word is
// being processed; done pulses for one cycle with result/flags valid, and
// result/flags hold until the next accepted start. Other starts are dropped.
module alu_serial_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ainvert,
  input  logic             bnegate,
  input  logic [2:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             zero,
  output logic             err,
  output logic             s_a,
  output logic             s_b,
  output logic             s_cin,
  output logic             s_ainvert,
  output logic             s_bnegate,
  output logic             s_less,
  output logic [2:0]       s_op,
  input  logic             s_result,
  input  logic             s_cout,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    SLT_FIX = 2'd2,
    FIN     = 2'd3
  } state_t;

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST_BIT = IW'(WIDTH - 1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b111;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [2:0]       op_q, op_d;
  logic             ainv_q, ainv_d, bneg_q, bneg_d;
  logic             carry_q, carry_d;
  logic [IW-1:0]    i_q, i_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             ovf_q, ovf_d, err_q, err_d;
  logic             accept, op_ok, op_arith;

  assign accept   = (state_q == IDLE) && start;
  assign op_ok    = (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
                    (op == OP_XOR) || (op == OP_SLT);
  assign op_arith = (op_q == OP_ADD) || (op_q == OP_SLT);

  // Next-state and datapath update for the serial walk.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    ainv_d   = ainv_q;
    bneg_d   = bneg_q;
    carry_d  = carry_q;
    i_d      = i_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          op_d     = op;
          ainv_d   = ainvert;
          bneg_d   = bnegate;
          carry_d  = bnegate;
          i_d      = '0;
          result_d = '0;
          ovf_d    = 1'b0;
          err_d    = 1'b0;
          if (op_ok) begin
            state_d = RUN;
          end else begin
            err_d   = 1'b1;
            state_d = FIN;
          end
        end
      end
      RUN: begin
        result_d[i_q] = s_result;
        carry_d       = s_cout;
        i_d           = i_q + IW'(1);
        if (i_q == LAST_BIT) begin
          // carry_q is the carry into the MSB at this point.
          ovf_d   = op_arith ? (carry_q ^ s_cout) : 1'b0;
          state_d = (op_q == OP_SLT) ? SLT_FIX : FIN;
        end
      end
      SLT_FIX: begin
        result_d = {{(WIDTH-1){1'b0}}, result_q[WIDTH-1] ^ ovf_q};
        state_d  = FIN;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == RUN) || (state_d == SLT_FIX);
    done_d = (state_d == FIN);
  end

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 3'b000;
      ainv_q   <= 1'b0;
      bneg_q   <= 1'b0;
      carry_q  <= 1'b0;
      i_q      <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      ainv_q   <= ainv_d;
      bneg_q   <= bneg_d;
      carry_q  <= carry_d;
      i_q      <= i_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

`ifdef ALU_SERIAL_ZERO_FLAG_EN
  logic zero_q, zero_d;

  // Zero flag follows the final result on the edge that raises done.
  always_comb begin
    zero_d = zero_q;
    if (state_d == FIN) begin
      zero_d = (result_d == '0);
    end else if (accept) begin
      zero_d = 1'b0;
    end
  end

  // Zero flag register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
    end else begin
      zero_q <= zero_d;
    end
  end

  assign zero = zero_q;
`else
  assign zero = 1'b0;
`endif

  // Slice drive: active only while walking bits, otherwise all zero.
  always_comb begin
    s_a       = 1'b0;
    s_b       = 1'b0;
    s_cin     = 1'b0;
    s_ainvert = 1'b0;
    s_bnegate = 1'b0;
    s_less    = 1'b0;
    s_op      = 3'b000;
    if (state_q == RUN) begin
      s_a       = a_q[i_q];
      s_b       = b_q[i_q];
      s_cin     = carry_q;
      s_ainvert = ainv_q;
      s_bnegate = bneg_q;
      s_op      = (op_q == OP_SLT) ? OP_ADD : op_q;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign overflow  = ovf_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule
